// File: rtl/mem_array_pkg.sv
// Shared types and helpers for the R x C memory array datapath.
package mem_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    // Index width that never collapses to zero bits, so ports stay legal for n == 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Even parity over a zero-extended word.
    function automatic logic parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mem_array_core.sv
// Storage for R x C words: synchronous write, combinational read, with address range check.
// Optional MEM_PARITY_EN adds one even-parity bit per word and a read-side mismatch flag.
module mem_array_core
    import mem_array_pkg::*;
#(
    parameter int R = 4,
    parameter int C = 4,
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [idx_w(R)-1:0] wr_row,
    input  logic [idx_w(C)-1:0] wr_col,
    input  logic [N-1:0]        wdata,
    input  logic [idx_w(R)-1:0] rd_row,
    input  logic [idx_w(C)-1:0] rd_col,
`ifdef MEM_PARITY_EN
    output logic                rd_perr,
`endif
    output logic [N-1:0]        rdata
);

    logic [N-1:0] mem [R][C];
`ifdef MEM_PARITY_EN
    logic         par_mem [R][C];
`endif

    logic wr_ok;
    logic rd_ok;

    // Addresses past R/C only exist when R or C is not a power of two.
    assign wr_ok = (int'(wr_row) < R) && (int'(wr_col) < C);
    assign rd_ok = (int'(rd_row) < R) && (int'(rd_col) < C);

    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[wr_row][wr_col] <= wdata;
`ifdef MEM_PARITY_EN
            par_mem[wr_row][wr_col] <= parity(32'(wdata));
`endif
        end
    end

    always_comb begin
        rdata = '0;
`ifdef MEM_PARITY_EN
        rd_perr = 1'b0;
`endif
        if (rd_ok) begin
            rdata = mem[rd_row][rd_col];
`ifdef MEM_PARITY_EN
            rd_perr = parity(32'(mem[rd_row][rd_col])) != par_mem[rd_row][rd_col];
`endif
        end
    end

endmodule

// File: rtl/mem_array_datapath.sv
// Access FSM, read latency counter and output registers around mem_array_core.
// Optional MEM_PARITY_EN adds the parity_err output.
module mem_array_datapath
    import mem_array_pkg::*;
#(
    parameter int R      = 4,
    parameter int C      = 4,
    parameter int N      = 4,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                req,
    input  logic                rw,
    input  logic [idx_w(R)-1:0] ar,
    input  logic [idx_w(C)-1:0] ac,
    input  logic [N-1:0]        wdata,
    output logic [N-1:0]        rdata,
    output logic                valid,
`ifdef MEM_PARITY_EN
    output logic                parity_err,
`endif
    output logic                busy
);

    localparam int RW   = idx_w(R);
    localparam int CW   = idx_w(C);
    localparam int CNTW = idx_w(RD_LAT);

    state_t            state;
    state_t            state_nx;
    logic [CNTW-1:0]   cnt;
    logic [RW-1:0]     row_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     rd_row;
    logic [CW-1:0]     rd_col;
    logic [N-1:0]      core_rdata;
    logic              rd_accept;
    logic              wr_accept;
`ifdef MEM_PARITY_EN
    logic              core_perr;
    logic              perr_q;
`endif

    assign rd_accept = (state == IDLE) && cs && req && rw;
    assign wr_accept = (state == IDLE) && cs && req && !rw;

    // In IDLE the live address feeds the core so RD_LAT == 1 can capture on the accept edge.
    assign rd_row = (state == IDLE) ? ar : row_q;
    assign rd_col = (state == IDLE) ? ac : col_q;

    mem_array_core #(.R(R), .C(C), .N(N)) u_core (
        .clk    (clk),
        .we     (wr_accept),
        .wr_row (ar),
        .wr_col (ac),
        .wdata  (wdata),
        .rd_row (rd_row),
        .rd_col (rd_col),
`ifdef MEM_PARITY_EN
        .rd_perr(core_perr),
`endif
        .rdata  (core_rdata)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rd_accept) state_nx = (RD_LAT > 1) ? RD_WAIT : RD_DONE;
            RD_WAIT: begin
                if (!cs)           state_nx = IDLE;
                else if (cnt == 0) state_nx = RD_DONE;
            end
            RD_DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
`ifdef MEM_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (rd_accept)
                cnt <= CNTW'(RD_LAT - 1);
            else if (state == RD_WAIT && cnt != 0)
                cnt <= cnt - 1'b1;
            // Output data is captured on the edge entering RD_DONE so it is valid with the pulse.
            if (state_nx == RD_DONE) begin
                rdata <= core_rdata;
`ifdef MEM_PARITY_EN
                perr_q <= core_perr;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_accept) begin
            row_q <= ar;
            col_q <= ac;
        end
    end

    assign valid = (state == RD_DONE);
    assign busy  = (state == RD_WAIT);
`ifdef MEM_PARITY_EN
    assign parity_err = valid && perr_q;
`endif

endmodule

// File: tb/tb_mem_array_datapath.sv
// Self-checking bench for mem_array_datapath (R=C=N=4, RD_LAT=2) against an array-based model.
// Define MEM_PARITY_EN to also exercise the parity error output.
module tb_mem_array_datapath;

    localparam int R      = 4;
    localparam int C      = 4;
    localparam int N      = 4;
    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       req;
    logic       rw;
    logic [1:0] ar;
    logic [1:0] ac;
    logic [3:0] wdata;
    logic [3:0] rdata;
    logic       valid;
    logic       busy;
`ifdef MEM_PARITY_EN
    logic       parity_err;
`endif

    mem_array_datapath #(.R(R), .C(C), .N(N), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .req       (req),
        .rw        (rw),
        .ar        (ar),
        .ac        (ac),
        .wdata     (wdata),
        .rdata     (rdata),
        .valid     (valid),
`ifdef MEM_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         vcnt  = 0;
    logic [3:0] model [R][C];
    logic [3:0] last_rd;

    always @(negedge clk) if (valid === 1'b1) vcnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_perr(input string tag, input logic exp);
`ifdef MEM_PARITY_EN
        chk(tag, 32'(parity_err), 32'(exp));
`endif
    endtask

    task automatic do_write(input int r, input int c, input int d);
        cs = 1'b1; req = 1'b1; rw = 1'b0;
        ar = 2'(r); ac = 2'(c); wdata = 4'(d);
        @(posedge clk); #1;
        req = 1'b0;
        model[r][c] = 4'(d);
        chk("wr_busy", 32'(busy), 0);
        chk("wr_valid", 32'(valid), 0);
    endtask

    // Read with optional requests injected while the read is in flight; they must be ignored.
    task automatic do_read(input int r, input int c, input bit inject, input int inj_d,
                           input logic exp_perr);
        logic [3:0] exp;
        exp = model[r][c];
        cs = 1'b1; req = 1'b1; rw = 1'b1;
        ar = 2'(r); ac = 2'(c);
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (inject) begin
                req = 1'b1;
                if (k == 0) begin
                    rw = 1'b0; ar = 2'(r); ac = 2'(c); wdata = 4'(inj_d);
                end else begin
                    rw = 1'b1; ar = 2'(R - 1); ac = 2'(C - 1);
                end
            end
            chk("rd_busy", 32'(busy), 1);
            chk("rd_valid_early", 32'(valid), 0);
            chk("rd_hold", 32'(rdata), 32'(last_rd));
            chk_perr("rd_perr_early", 1'b0);
            @(posedge clk); #1;
        end
        req = 1'b0;
        chk("rd_valid", 32'(valid), 1);
        chk("rd_busy_done", 32'(busy), 0);
        chk("rd_data", 32'(rdata), 32'(exp));
        chk_perr("rd_perr", exp_perr);
        last_rd = exp;
        @(posedge clk); #1;
        chk("rd_valid_once", 32'(valid), 0);
        chk("rd_busy_after", 32'(busy), 0);
        chk("rd_data_held", 32'(rdata), 32'(exp));
        chk_perr("rd_perr_after", 1'b0);
    endtask

    task automatic do_abort(input int r, input int c);
        cs = 1'b1; req = 1'b1; rw = 1'b1;
        ar = 2'(r); ac = 2'(c);
        @(posedge clk); #1;
        req = 1'b0;
        chk("ab_busy", 32'(busy), 1);
        cs = 1'b0;
        @(posedge clk); #1;
        chk("ab_busy_drop", 32'(busy), 0);
        chk("ab_valid", 32'(valid), 0);
        chk("ab_rdata", 32'(rdata), 32'(last_rd));
        @(posedge clk); #1;
        chk("ab_valid_late", 32'(valid), 0);
        chk("ab_rdata_late", 32'(rdata), 32'(last_rd));
        cs = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int v0;
        rst_n = 1'b0; cs = 1'b0; req = 1'b0; rw = 1'b0;
        ar = '0; ac = '0; wdata = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", 32'(rdata), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 0);

        // Write then read the next cycle.
        do_write(1, 2, 4'hA);
        do_read(1, 2, 1'b0, 0, 1'b0);

        // Full sweep.
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                do_write(r, c, r * 4 + c);
        v0 = vcnt;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                do_read(r, c, 1'b0, 0, 1'b0);
        chk("sweep_pulses", 32'(vcnt - v0), 16);

        // Requests while busy are dropped.
        do_write(0, 0, 4'h3);
        do_read(0, 0, 1'b1, 4'hF, 1'b0);
        do_read(0, 0, 1'b0, 0, 1'b0);

        // Abort by dropping cs.
        do_abort(2, 3);

        // Reset mid-read; array contents survive.
        do_write(2, 2, 4'h5);
        cs = 1'b1; req = 1'b1; rw = 1'b1; ar = 2'd1; ac = 2'd2;
        @(posedge clk); #1;
        req = 1'b0;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdata", 32'(rdata), 0);
        last_rd = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_idle", 32'(valid), 0);
        do_read(2, 2, 1'b0, 0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int op, r, c;
            op = $urandom_range(0, 3);
            r  = $urandom_range(0, R - 1);
            c  = $urandom_range(0, C - 1);
            case (op)
                0, 1:    do_write(r, c, $urandom_range(0, 15));
                2:       do_read(r, c, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'b0);
                default: do_abort(r, c);
            endcase
        end

`ifdef MEM_PARITY_EN
        do_write(2, 1, 4'h7);
        do_write(1, 1, 4'h9);
        dut.u_core.par_mem[2][1] = ~dut.u_core.par_mem[2][1];
        do_read(2, 1, 1'b0, 0, 1'b1);
        do_read(1, 1, 1'b0, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_array_datapath.md
Name: mem_array_datapath

Overview:
- Storage and access datapath for the 2D memory array: R x C words of N bits, addressed by decoded row/column.
- Sits directly downstream of the address-decode/handshake controller, which sends it ar/ac plus the cs/req/rw strobes. Returns the valid pulse that the controller converts into ready.
- Writes commit in one cycle. Reads complete after a fixed, parameterised access latency.

Parameters:
R, 4, number of rows (>=2)
C, 4, number of columns (>=2)
N, 4, data word width in bits
RD_LAT, 2, read access latency in cycles from request acceptance to valid (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cs  input  1  chip select
req  input  1  request strobe, sampled each cycle
rw  input  1  1 = read, 0 = write
ar  input  $clog2(R)  decoded row address
ac  input  $clog2(C)  decoded column address
wdata  input  N  write data
rdata  output  N  read data, held until the next read completes
valid  output  1  one-cycle pulse: rdata is valid
busy  output  1  read in flight; new requests are ignored

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, valid=0, busy=0, rdata=0, latency counter=0.
  - Array contents are NOT reset and are preserved across reset.
- FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE, request rules:
  - Request accepted when cs & req.
  - Write (rw=0): mem[ar][ac] <= wdata at that edge. Stay IDLE. No valid pulse.
  - Read (rw=1): latch ar/ac. Load counter with RD_LAT-1. Go to RD_WAIT if RD_LAT>1, else RD_DONE. busy=1 from the next cycle.
- RD_WAIT:
  - Counter decrements each cycle; at 0, go to RD_DONE.
  - cs & req ignored, including writes; no queuing.
  - cs deasserted: read aborts. Return to IDLE next edge, no valid, rdata unchanged.
- RD_DONE:
  - rdata <= mem[latched row][latched col]; valid=1 for exactly this one cycle.
  - Next state IDLE; busy=0 in the same cycle valid is high.
  - A new cs&req in RD_DONE is ignored.
- Latency: request sampled at edge T0 -> valid high during cycle after edge T0+RD_LAT. Back-to-back reads are therefore spaced RD_LAT+1 cycles.
- Out-of-range addresses (R or C not a power of two):
  - Write to ar>=R or ac>=C is dropped.
  - Read completes normally with rdata=0.
- Read-after-write: a write accepted at T0 is visible to a read accepted at T0+1.
- Reset asserted mid-read: read discarded, outputs return to reset values immediately.

Optional Feature:
- Macro MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from wdata on write.
  - New output parity_err (1 bit) is asserted alongside valid when the stored parity mismatches the read word; reset value 0.
  - Only asserts in the valid cycle.
- Undefined: no parity storage, no parity_err port. Behaviour is otherwise identical.

Decomposition:
- Package mem_array_pkg holds:
  - FSM state enum (IDLE, RD_WAIT, RD_DONE).
  - Width helper constants/functions for row, column and counter widths ($clog2 of R, C, RD_LAT).
  - Parity function.
- Sub-module mem_array_core: pure storage, R*C words (+parity bit when enabled), synchronous write, combinational read by row/col, with the range check.
- The top level holds the FSM, latency counter and output registers.

Test Plan (R=C=N=4, RD_LAT=2):
- Reset then write/read: release rst_n; write 4'hA to (1,2); read (1,2) next cycle -> valid high exactly 1 cycle, 2 cycles after read accept, rdata=4'hA; busy high for 2 cycles.
- Full sweep: write value (r*4+c) to all 16 locations; read each back -> every rdata matches, 16 valid pulses, back-to-back reads spaced 3 cycles apart.
- Ignore while busy: read (0,0)=4'h3; during RD_WAIT issue write 4'hF to (0,0) and a read of (3,3) -> both ignored; later read (0,0) returns 4'h3.
- Abort and reset: drop cs during RD_WAIT -> no valid, rdata keeps its old value. Assert rst_n low mid-read -> valid=0, busy=0, rdata=0 immediately, and a previously written (2,2)=4'h5 still reads 4'h5 after reset.
- MEM_PARITY_EN: write 4'h7 to (2,1), force the stored parity bit flipped, read (2,1) -> parity_err=1 in the valid cycle only. An unmodified location reads with parity_err=0.
